// File: rtl/pow_pkg.sv
// pow_pkg: shared types and constants for the power-result display path.
//   state_t         converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t     one packed BCD digit
//   BCD_ADJ_THRESH  digit value at and above which double-dabble adds 3
//   clog2()         ceiling log2, usable in constant expressions
package pow_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pow_res_bcd_converter_if.sv
// pow_res_bcd_converter_if: result-in / BCD-out bundle of the converter.
//   in_vld, in_data           upstream power result (no backpressure)
//   busy, bcd_vld, bcd,
//   dig_en, ovf               converter status and display digits
// master: upstream/consumer side; slave: the converter.
interface pow_res_bcd_converter_if #(
  parameter int unsigned w    = 8,
  parameter int unsigned ndig = 3
);

  logic              in_vld;
  logic [w-1:0]      in_data;
  logic              busy;
  logic              bcd_vld;
  logic [4*ndig-1:0] bcd;
  logic [ndig-1:0]   dig_en;
  logic              ovf;

  modport master (
    output in_vld, in_data,
    input  busy, bcd_vld, bcd, dig_en, ovf
  );

  modport slave (
    input  in_vld, in_data,
    output busy, bcd_vld, bcd, dig_en, ovf
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: combinational double-dabble digit correction.
//   d_i  BCD digit before the shift
//   d_o  d_i + 3 when d_i >= BCD_ADJ_THRESH, otherwise d_i
module bcd_digit_adjust
  import pow_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  always_comb begin
    d_o = (d_i >= BCD_ADJ_THRESH) ? bcd_digit_t'(d_i + 4'd3) : d_i;
  end

endmodule

// File: rtl/pow_res_bcd_converter.sv
// pow_res_bcd_converter: sequential binary-to-BCD converter (shift-add-3)
// feeding the seven-segment driver, with a one-entry pending buffer because
// upstream cannot be stalled.
//   clk     clock
//   rst     synchronous active-high reset, overrides clk_en
//   clk_en  clock enable; all state advances only on enabled edges
//   bus     slave modport: in_vld/in_data in; busy, bcd_vld, bcd, dig_en,
//           ovf out
// Optional feature: define BCD_LEADING_ZERO_BLANK_EN to blank leading-zero
// digits through dig_en (digit 0 always lit); otherwise dig_en is all ones.
// Parameters w/ndig must match those of the connected interface instance,
// and 10**ndig must exceed 2**w - 1.
module pow_res_bcd_converter
  import pow_pkg::*;
#(
  parameter int unsigned w    = 8,
  parameter int unsigned ndig = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  pow_res_bcd_converter_if.slave bus
);

  localparam int unsigned BW = 4 * ndig;
  localparam int unsigned SW = BW + w;
  localparam int unsigned CW = (clog2(w) > 0) ? clog2(w) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   scr_q, scr_d;       // {bcd_acc, bin}
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [w-1:0]    pend_data_q, pend_data_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            bcd_vld_q, bcd_vld_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]   adj;
  logic [SW-1:0]   adj_scr;

  for (genvar g = 0; g < ndig; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (scr_q[w + 4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d     = state_q;
    scr_d       = scr_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    bcd_d       = bcd_q;
    bcd_vld_d   = 1'b0;
    ovf_d       = ovf_q;
    adj_scr     = {adj, scr_q[w-1:0]};

    unique case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          scr_d      = {{BW{1'b0}}, pend_data_q};
          cnt_d      = '0;
          state_d    = SHIFT;
          // Older pending entry goes first; a same-edge arrival takes its slot.
          pend_vld_d = bus.in_vld;
          if (bus.in_vld) begin
            pend_data_d = bus.in_data;
          end
        end else if (bus.in_vld) begin
          scr_d   = {{BW{1'b0}}, bus.in_data};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = {adj_scr[SW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d     = scr_q[SW-1:w];
        bcd_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Arrivals during a conversion park in the pending slot; latest wins.
    if (state_q != IDLE && bus.in_vld) begin
      pend_vld_d  = 1'b1;
      pend_data_d = bus.in_data;
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scr_q       <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      bcd_q       <= '0;
      bcd_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      scr_q       <= scr_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      bcd_q       <= bcd_d;
      bcd_vld_q   <= bcd_vld_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [ndig-1:0] dig_en_q, dig_en_d;
  logic [ndig-1:0] blank_en;

  // A digit is lit if it or any more significant digit is nonzero.
  always_comb begin
    logic found;
    found    = 1'b0;
    blank_en = '1;
    for (int unsigned i = ndig - 1; i >= 1; i--) begin
      if (scr_q[w + 4*i +: 4] != 4'd0) begin
        found = 1'b1;
      end
      blank_en[i] = found;
    end
    dig_en_d = (state_q == DONE) ? blank_en : dig_en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en_q <= '1;
    end else if (clk_en) begin
      dig_en_q <= dig_en_d;
    end
  end

  assign bus.dig_en = dig_en_q;
`else
  assign bus.dig_en = '1;
`endif

  assign bus.busy    = busy_q;
  assign bus.bcd_vld = bcd_vld_q;
  assign bus.bcd     = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule
